// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM controller: FSM state encodings, beat
// counts per transaction type, the default base address, and a helper that
// says whether the current beat is the final one of its transaction.
package sram_controller_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RD   = 2'd1;
  localparam logic [1:0] ST_WR   = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int RD_BEATS = 4;  // 4 x 16-bit half-words = one 64-bit line
  localparam int WR_BEATS = 2;  // 2 x 16-bit half-words = one 32-bit word

  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

  function automatic logic is_last_beat(input logic [1:0] st, input logic [1:0] beat);
    if (st == ST_RD) return beat == 2'(RD_BEATS - 1);
    return beat == 2'(WR_BEATS - 1);
  endfunction

endpackage

// File: rtl/sram_controller_if.sv
// Request/response bus between the cache controller (master) and the SRAM
// controller (slave).
//   read, write   : requests, held high by the master until ready
//   address       : byte address
//   wdata         : 32-bit store data
//   rdata         : 64-bit assembled line, valid with ready
//   ready         : one-cycle completion pulse
interface sram_controller_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [63:0] rdata;
  logic        ready;

  modport master (output read, write, address, wdata, input rdata, ready);
  modport slave  (input read, write, address, wdata, output rdata, ready);
endinterface

// File: rtl/sram_wait_counter.sv
// Per-beat wait counter. load starts a new beat of WAIT_CYCLES cycles; the
// count then runs down while en is high.
//   clk, rst : clock, asynchronous active-high reset
//   load     : start a new beat (takes priority over en)
//   en       : count down
//   last     : current cycle is the final cycle of the beat
//   penult   : current cycle is the second-to-last cycle of the beat
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic last,
  output logic penult
);

  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= CW'(WAIT_CYCLES - 1);
    end else if (en && count != '0) begin
      count <= count - CW'(1);
    end
  end

  assign last   = (count == '0);
  assign penult = (count == CW'(1));

endmodule

// File: rtl/sram_controller.sv
// Sequences cache-controller miss-fill reads (64-bit) and write-through
// stores (32-bit) onto a 16-bit asynchronous SRAM. Reads gather four
// half-words, writes emit two. Completion is a registered one-cycle ready
// pulse followed by one dead cycle so a held request is not re-issued early.
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : request/response interface (slave side)
//   sram_addr   : half-word address
//   sram_dq_i   : data from the pad
//   sram_dq_o   : data to the pad, driven when sram_dq_oe=1
//   sram_we_n, sram_oe_n, sram_ce_n : active-low SRAM strobes
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = DEFAULT_BASE_ADDR,
  parameter int          WAIT_CYCLES = 3,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  sram_controller_if.slave   bus,
  output logic [SRAM_AW-1:0] sram_addr,
  input  logic [15:0]        sram_dq_i,
  output logic [15:0]        sram_dq_o,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n
);

  logic [1:0]         state;
  logic [1:0]         beat;
  logic [15:0]        wdata_hi;   // upper store half, needed on the second beat
  logic [63:0]        rdata_q;
  logic               ready_q;
  logic [31:0]        offset;
  logic [SRAM_AW-1:0] rd_base;
  logic [SRAM_AW-1:0] wr_base;
  logic               busy;
  logic               start;
  logic               next_beat;
  logic               wait_last;
  logic               wait_penult;

  // Byte offset wraps modulo 2^32; bases are aligned to the transfer size.
  assign offset  = bus.address - BASE_ADDR;
  assign rd_base = {offset[SRAM_AW:3], 2'b00};
  assign wr_base = {offset[SRAM_AW:2], 1'b0};

  assign busy      = (state == ST_RD) || (state == ST_WR);
  assign start     = (state == ST_IDLE) && (bus.read || bus.write);
  assign next_beat = busy && wait_last && !is_last_beat(state, beat);

  sram_wait_counter #(.WAIT_CYCLES(WAIT_CYCLES)) u_wait (
    .clk    (clk),
    .rst    (rst),
    .load   (start || next_beat),
    .en     (busy),
    .last   (wait_last),
    .penult (wait_penult)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      beat       <= '0;
      wdata_hi   <= '0;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_we_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_ce_n  <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          beat <= '0;
          // Write wins when both requests are present.
          if (bus.write) begin
            state      <= ST_WR;
            wdata_hi   <= bus.wdata[31:16];
            sram_addr  <= wr_base;
            sram_dq_o  <= bus.wdata[15:0];
            sram_dq_oe <= 1'b1;
            sram_we_n  <= 1'b0;
            sram_ce_n  <= 1'b0;
          end else if (bus.read) begin
            state     <= ST_RD;
            sram_addr <= rd_base;
            sram_oe_n <= 1'b0;
            sram_ce_n <= 1'b0;
          end
        end
        ST_RD: begin
          if (wait_last) begin
            rdata_q[16*beat +: 16] <= sram_dq_i;
            if (is_last_beat(state, beat)) begin
              state     <= ST_DONE;
              ready_q   <= 1'b1;
              sram_oe_n <= 1'b1;
              sram_ce_n <= 1'b1;
            end else begin
              beat      <= beat + 2'd1;
              sram_addr <= sram_addr + SRAM_AW'(1);
            end
          end
        end
        ST_WR: begin
          if (wait_last) begin
            if (is_last_beat(state, beat)) begin
              state      <= ST_DONE;
              ready_q    <= 1'b1;
              sram_dq_oe <= 1'b0;
              sram_we_n  <= 1'b1;
              sram_ce_n  <= 1'b1;
            end else begin
              beat      <= beat + 2'd1;
              sram_addr <= sram_addr + SRAM_AW'(1);
              sram_dq_o <= wdata_hi;
              sram_we_n <= 1'b0;
            end
          end else if (wait_penult) begin
            // Raise we_n one cycle early so address/data are stable at its rising edge.
            sram_we_n <= 1'b1;
          end
        end
        default: state <= ST_IDLE;  // ST_DONE: one dead cycle, requests ignored
      endcase
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (WAIT_CYCLES=3 and =1), each with
// a behavioural 16-bit SRAM that commits a write on the rising edge of
// we_n. A scoreboard queue per instance holds the expected completion
// (latency and, for reads, the line); a monitor pops it on every ready pulse.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          start;
    int          lat;
    bit          is_read;
    logic [63:0] rdata;
    string       name;
  } item_t;

  item_t sb3[$];
  item_t sb1[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // ---------------- DUTs ----------------
  sram_controller_if bus3();
  sram_controller_if bus1();

  logic [17:0] a3, a1;
  logic [15:0] di3, do3, di1, do1;
  logic        dqoe3, we3, oen3, ce3, dqoe1, we1, oen1, ce1;

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(3), .SRAM_AW(18)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3), .sram_addr(a3), .sram_dq_i(di3), .sram_dq_o(do3),
    .sram_dq_oe(dqoe3), .sram_we_n(we3), .sram_oe_n(oen3), .sram_ce_n(ce3));

  sram_controller #(.BASE_ADDR(32'd1024), .WAIT_CYCLES(1), .SRAM_AW(18)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .sram_addr(a1), .sram_dq_i(di1), .sram_dq_o(do1),
    .sram_dq_oe(dqoe1), .sram_we_n(we1), .sram_oe_n(oen1), .sram_ce_n(ce1));

  // ---------------- SRAM models ----------------
  // Data/address seen while we_n is low are committed on the we_n rising
  // edge; a rising edge caused by reset is an aborted cycle and writes nothing.
  logic [15:0] mem3 [0:15];
  logic [15:0] mem1 [0:15];
  logic [3:0]  pa3, pa1;
  logic [15:0] pd3, pd1;
  bit          pv3 = 0, pv1 = 0;

  assign di3 = (!ce3 && !oen3) ? mem3[a3[3:0]] : 16'h0000;
  assign di1 = (!ce1 && !oen1) ? mem1[a1[3:0]] : 16'h0000;

  initial begin
    for (int i = 0; i < 16; i++) mem3[i] = 16'(16'h1111 * (i + 1));
    forever begin
      @(negedge clk or posedge we3);
      if (we3) begin
        if (pv3 && !rst) mem3[pa3] = pd3;
        pv3 = 0;
      end else if (!ce3 && dqoe3) begin
        pa3 = a3[3:0]; pd3 = do3; pv3 = 1;
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mem1[i] = 16'(16'h1111 * (i + 1));
    forever begin
      @(negedge clk or posedge we1);
      if (we1) begin
        if (pv1 && !rst) mem1[pa1] = pd1;
        pv1 = 0;
      end else if (!ce1 && dqoe1) begin
        pa1 = a1[3:0]; pd1 = do1; pv1 = 1;
      end
    end
  end

  // ---------------- Monitors ----------------
  item_t m3, m1;

  initial forever begin
    @(negedge clk);
    if (bus3.ready === 1'b1) begin
      if (sb3.size() == 0) begin
        tests++; fails++;
        $display("FAIL w3 unexpected ready at cycle %0d, expected no completion", cyc);
      end else begin
        m3 = sb3.pop_front();
        check({m3.name, " latency"}, 64'(cyc - m3.start), 64'(m3.lat));
        if (m3.is_read) check({m3.name, " rdata"}, bus3.rdata, m3.rdata);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (bus1.ready === 1'b1) begin
      if (sb1.size() == 0) begin
        tests++; fails++;
        $display("FAIL w1 unexpected ready at cycle %0d, expected no completion", cyc);
      end else begin
        m1 = sb1.pop_front();
        check({m1.name, " latency"}, 64'(cyc - m1.start), 64'(m1.lat));
        if (m1.is_read) check({m1.name, " rdata"}, bus1.rdata, m1.rdata);
      end
    end
  end

  // ---------------- Driver ----------------
  bit          oe_seen;
  int          we_low;
  logic [17:0] aseq[$];

  // Issue one request, drop it (and scramble address/data) right after it is
  // accepted, and wait for ready while recording strobe activity.
  task automatic req(input bit one, input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [63:0] exp_rd, input int lat,
                     input string name);
    item_t it;
    int    n;
    logic [17:0] cur_a;
    @(negedge clk);
    it.start = cyc; it.lat = lat; it.is_read = rd && !wr; it.rdata = exp_rd; it.name = name;
    if (one) begin
      bus1.read = rd; bus1.write = wr; bus1.address = addr; bus1.wdata = wd; sb1.push_back(it);
    end else begin
      bus3.read = rd; bus3.write = wr; bus3.address = addr; bus3.wdata = wd; sb3.push_back(it);
    end
    oe_seen = 0; we_low = 0; aseq.delete();
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (n == 0) begin
        if (one) begin
          bus1.read = 0; bus1.write = 0; bus1.address = 32'hFFFF_FFF0; bus1.wdata = '0;
        end else begin
          bus3.read = 0; bus3.write = 0; bus3.address = 32'hFFFF_FFF0; bus3.wdata = '0;
        end
      end
      cur_a = one ? a1 : a3;
      if (one ? !oen1 : !oen3) begin
        oe_seen = 1;
        if (aseq.size() == 0 || aseq[$] != cur_a) aseq.push_back(cur_a);
      end
      if (one ? !we1 : !we3) we_low++;
      if (one ? bus1.ready : bus3.ready) break;
    end
    if (n == 100) begin
      tests++; fails++;
      $display("FAIL %s timeout: no ready after %0d cycles, expected after %0d", name, n, lat);
    end
  endtask

  task automatic check_reset3(input string name);
    check({name, " strobes"}, {ce3, oen3, we3, dqoe3}, 4'b1110);
    check({name, " addr/dq"}, {a3, do3}, 34'd0);
    check({name, " ready"}, bus3.ready, 1'b0);
    check({name, " rdata"}, bus3.rdata, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  // ---------------- Stimulus ----------------
  initial begin
    item_t it;
    int    s, n, pulses;
    bus3.read = 0; bus3.write = 0; bus3.address = '0; bus3.wdata = '0;
    bus1.read = 0; bus1.write = 0; bus1.address = '0; bus1.wdata = '0;
    repeat (3) @(negedge clk);
    check_reset3("reset");
    rst = 0;

    // 1: line read, half-words assembled LS-first, address steps 0..3
    req(0, 1, 0, 32'd1024, '0, 64'h4444_3333_2222_1111, 13, "t1 read");
    check("t1 addr steps", {46'(aseq.size()), aseq[0]} | 64'({aseq[1], aseq[2], aseq[3]}) << 18,
          {46'd4, 18'd0} | 64'({18'd1, 18'd2, 18'd3}) << 18);

    // 2: word write then read back
    req(0, 0, 1, 32'd1028, 32'hDEAD_BEEF, '0, 7, "t2 write");
    check("t2 mem[2]", mem3[2], 16'hBEEF);
    check("t2 mem[3]", mem3[3], 16'hDEAD);
    check("t2 we_n low cycles", we_low, 4);
    req(0, 1, 0, 32'd1024, '0, 64'hDEAD_BEEF_2222_1111, 13, "t2 read");

    // 3: read and write together -> write wins, no read strobe
    req(0, 1, 1, 32'd1032, 32'hCAFE_F00D, '0, 7, "t3 write");
    check("t3 oe_n low seen", oe_seen, 1'b0);
    check("t3 mem[4]", mem3[4], 16'hF00D);
    check("t3 mem[5]", mem3[5], 16'hCAFE);

    // 4: read held across ready -> back-to-back reads, dead DONE cycle
    @(negedge clk);
    bus3.read = 1; bus3.address = 32'd1024;
    it.start = cyc; it.lat = 13; it.is_read = 1; it.rdata = 64'hDEAD_BEEF_2222_1111; it.name = "t4 read a";
    sb3.push_back(it);
    pulses = 0;
    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      if (bus3.ready) begin
        pulses++;
        check("t4 done strobes", {ce3, oen3, we3, dqoe3}, 4'b1110);
        if (pulses == 1) begin
          it.start = cyc + 1; it.name = "t4 read b";
          sb3.push_back(it);
        end else begin
          bus3.read = 0;
        end
      end
    end
    check("t4 ready pulses", pulses, 2);

    // 5: reset during the second wait cycle of write beat 1
    @(negedge clk);
    bus3.write = 1; bus3.address = 32'd1032; bus3.wdata = 32'h1234_5678;
    it.start = cyc; it.lat = 7; it.is_read = 0; it.rdata = '0; it.name = "t5 write";
    sb3.push_back(it);
    s = cyc; n = 0;
    while (cyc != s + 5 && n < 50) begin @(negedge clk); n++; end
    check("t5 we_n before reset", {we3, a3}, {1'b0, 18'd5});
    rst = 1;
    #1;
    check_reset3("t5 async reset");
    bus3.write = 0;
    sb3.delete();
    @(negedge clk);
    check("t5 mem[4]", mem3[4], 16'h5678);
    check("t5 mem[5]", mem3[5], 16'hCAFE);
    rst = 0;
    req(0, 1, 0, 32'd1024, '0, 64'hDEAD_BEEF_2222_1111, 13, "t5 read after reset");

    // 6: WAIT_CYCLES=1 instance
    req(1, 1, 0, 32'd1024, '0, 64'h4444_3333_2222_1111, 5, "t6 read");
    req(1, 0, 1, 32'd1028, 32'h5555_6666, '0, 3, "t6 write");
    check("t6 we_n low cycles", we_low, 2);
    check("t6 mem[3]", mem1[3], 16'h5555);

    repeat (4) @(negedge clk);
    check("outstanding w3", 64'(sb3.size()), 64'd0);
    check("outstanding w1", 64'(sb1.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
